// File: rtl/pa_fmau_mult_arb.sv
// pa_fmau_mult_arb: two-requester round-robin arbiter in front of the shared
// 24x24 FMAU multiplier. Tracks the single EX2 result slot with back-pressure
// and flush, and sequences multiplier warm-up cycles when no result is in flight.
module pa_fmau_mult_arb #(
  parameter int WARM_CYCLES = 4
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        r0_req,
  input  logic        r1_req,
  input  logic [23:0] r0_frac_a,
  input  logic [23:0] r0_frac_b,
  input  logic [23:0] r1_frac_a,
  input  logic [23:0] r1_frac_b,
  output logic        r0_gnt,
  output logic        r1_gnt,
  output logic [23:0] ex1_frac_0,
  output logic [23:0] ex1_frac_1,
  output logic        ctrl_dp_ex1_inst_pipe_down,
  output logic        ctrl_xx_ex1_warm_up,
  input  logic [47:0] ex2_mult_data,
  output logic        res_vld,
  output logic        res_id,
  output logic [47:0] res_data,
  input  logic        res_rdy,
  input  logic        warm_up_req,
  input  logic        flush
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WARM_WAIT = 2'd1;
  localparam logic [1:0] ST_WARM      = 2'd2;

  localparam logic [2:0] WARM_LOAD = 3'(WARM_CYCLES);

  logic [1:0] state_q, state_d;
  logic       ex2_vld_q, ex2_vld_d;
  logic       ex2_id_q, ex2_id_d;
  logic [2:0] warm_cnt_q, warm_cnt_d;
  // 0: r0 wins a tie, 1: r1 wins a tie
  logic       prio_q, prio_d;

  logic issue_ok;
  logic gnt0;
  logic gnt1;
  logic any_gnt;

  // Issue is allowed only when idle, not flushed, and the EX2 slot is free or
  // being drained this cycle. Reset is folded in so grants stay low during it.
  always_comb begin
    issue_ok = !cpurst && (state_q == ST_IDLE) && !flush && (!ex2_vld_q || res_rdy);
  end

  // Round-robin grant: the requester not granted last wins a tie.
  always_comb begin
    gnt0    = issue_ok && r0_req && (!r1_req || !prio_q);
    gnt1    = issue_ok && r1_req && (!r0_req ||  prio_q);
    any_gnt = gnt0 || gnt1;
  end

  // Operand mux to the shared multiplier, zero when nothing is issued.
  always_comb begin
    ex1_frac_0 = '0;
    ex1_frac_1 = '0;
    if (gnt0) begin
      ex1_frac_0 = r0_frac_a;
      ex1_frac_1 = r0_frac_b;
    end else if (gnt1) begin
      ex1_frac_0 = r1_frac_a;
      ex1_frac_1 = r1_frac_b;
    end
  end

  // Grant and multiplier control outputs.
  always_comb begin
    r0_gnt                     = gnt0;
    r1_gnt                     = gnt1;
    ctrl_dp_ex1_inst_pipe_down = any_gnt;
    ctrl_xx_ex1_warm_up        = (state_q == ST_WARM);
  end

  // Result port; product is masked while the slot is empty so outputs read
  // zero during and right after reset.
  always_comb begin
    res_vld  = ex2_vld_q;
    res_id   = ex2_id_q;
    res_data = ex2_vld_q ? ex2_mult_data : '0;
  end

  // Pointer moves only on a grant: after granting r0, r1 gets the next tie.
  always_comb begin
    prio_d = prio_q;
    if (any_gnt) begin
      prio_d = gnt0;
    end
  end

  // EX2 slot tracking: flush kills, a grant refills (even while draining),
  // an accept without a refill empties, otherwise hold.
  always_comb begin
    ex2_vld_d = ex2_vld_q;
    ex2_id_d  = ex2_id_q;
    if (flush) begin
      ex2_vld_d = 1'b0;
    end else if (any_gnt) begin
      ex2_vld_d = 1'b1;
      ex2_id_d  = gnt1;
    end else if (ex2_vld_q && res_rdy) begin
      ex2_vld_d = 1'b0;
    end
  end

  // Warm-up sequencer: wait for the EX2 slot to empty, then emit exactly
  // WARM_LOAD warm-up cycles; flush does not abort the sequence.
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (warm_up_req) begin
          state_d = ST_WARM_WAIT;
        end
      end
      ST_WARM_WAIT: begin
        if (!ex2_vld_q) begin
          state_d    = ST_WARM;
          warm_cnt_d = WARM_LOAD;
        end
      end
      ST_WARM: begin
        warm_cnt_d = warm_cnt_q - 3'd1;
        if (warm_cnt_q == 3'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        warm_cnt_d = '0;
      end
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state_q    <= ST_IDLE;
      ex2_vld_q  <= 1'b0;
      ex2_id_q   <= 1'b0;
      warm_cnt_q <= '0;
      prio_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ex2_vld_q  <= ex2_vld_d;
      ex2_id_q   <= ex2_id_d;
      warm_cnt_q <= warm_cnt_d;
      prio_q     <= prio_d;
    end
  end

endmodule

// File: tb/tb_pa_fmau_mult_arb.sv
// Directed bench for pa_fmau_mult_arb with a behavioural one-stage multiplier.
module tb_pa_fmau_mult_arb;

  logic        clk;
  logic        rst;
  logic        r0_req, r1_req;
  logic [23:0] r0_frac_a, r0_frac_b, r1_frac_a, r1_frac_b;
  logic        r0_gnt, r1_gnt;
  logic [23:0] ex1_frac_0, ex1_frac_1;
  logic        pipe_down, warm_up;
  logic [47:0] ex2_mult_data;
  logic        res_vld, res_id;
  logic [47:0] res_data;
  logic        res_rdy, warm_up_req, flush;

  int n_checks = 0;
  int n_errors = 0;

  pa_fmau_mult_arb #(.WARM_CYCLES(4)) dut (
    .forever_cpuclk             (clk),
    .cpurst                     (rst),
    .r0_req                     (r0_req),
    .r1_req                     (r1_req),
    .r0_frac_a                  (r0_frac_a),
    .r0_frac_b                  (r0_frac_b),
    .r1_frac_a                  (r1_frac_a),
    .r1_frac_b                  (r1_frac_b),
    .r0_gnt                     (r0_gnt),
    .r1_gnt                     (r1_gnt),
    .ex1_frac_0                 (ex1_frac_0),
    .ex1_frac_1                 (ex1_frac_1),
    .ctrl_dp_ex1_inst_pipe_down (pipe_down),
    .ctrl_xx_ex1_warm_up        (warm_up),
    .ex2_mult_data              (ex2_mult_data),
    .res_vld                    (res_vld),
    .res_id                     (res_id),
    .res_data                   (res_data),
    .res_rdy                    (res_rdy),
    .warm_up_req                (warm_up_req),
    .flush                      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared multiplier stand-in: captures the product on pipe_down.
  always @(posedge clk or posedge rst) begin
    if (rst) ex2_mult_data <= '0;
    else if (pipe_down) ex2_mult_data <= 48'(ex1_frac_0) * 48'(ex1_frac_1);
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    r0_req = 1'b0; r1_req = 1'b0;
    r0_frac_a = 24'h800000; r0_frac_b = 24'h800000;
    r1_frac_a = 24'd7; r1_frac_b = 24'd11;
    res_rdy = 1'b0; warm_up_req = 1'b0; flush = 1'b0;

    // Reset asserted, with a pending request: outputs must stay 0
    #1 r0_req = 1'b1;
    #1;
    chk("rst_r0_gnt", 48'(r0_gnt), 48'd0);
    chk("rst_pipe_down", 48'(pipe_down), 48'd0);
    chk("rst_frac0", 48'(ex1_frac_0), 48'd0);
    chk("rst_res_vld", 48'(res_vld), 48'd0);
    chk("rst_res_data", res_data, 48'd0);
    chk("rst_warm_up", 48'(warm_up), 48'd0);
    r0_req = 1'b0;
    @(negedge clk) rst = 1'b0;
    tick();

    // First cycle after reset, nothing pending
    chk("post_rst_gnt", {46'd0, r1_gnt, r0_gnt}, 48'd0);
    chk("post_rst_res", {46'd0, res_vld, res_id}, 48'd0);
    chk("post_rst_frac1", 48'(ex1_frac_1), 48'd0);

    // Single r0 multiply 0x800000 * 0x800000
    r0_req = 1'b1; res_rdy = 1'b1;
    #1;
    chk("t35_r0_gnt", 48'(r0_gnt), 48'd1);
    chk("t35_r1_gnt", 48'(r1_gnt), 48'd0);
    chk("t35_pipe_down", 48'(pipe_down), 48'd1);
    chk("t35_frac0", 48'(ex1_frac_0), 48'h800000);
    chk("t35_frac1", 48'(ex1_frac_1), 48'h800000);
    tick();
    r0_req = 1'b0;
    #1;
    chk("t35_res_vld", 48'(res_vld), 48'd1);
    chk("t35_res_id", 48'(res_id), 48'd0);
    chk("t35_res_data", res_data, 48'h400000000000);
    chk("t35_no_gnt", 48'(r0_gnt), 48'd0);
    tick();
    chk("t35_drained", 48'(res_vld), 48'd0);

    // Lone r1 request: pointer then favours r0
    r0_frac_a = 24'd3; r0_frac_b = 24'd5;
    r1_req = 1'b1;
    #1;
    chk("r1_only_gnt", {46'd0, r1_gnt, r0_gnt}, 48'b10);
    chk("r1_only_frac0", 48'(ex1_frac_0), 48'd7);
    chk("r1_only_frac1", 48'(ex1_frac_1), 48'd11);
    tick();

    // Both requesting for 4 cycles: r0,r1,r0,r1
    r0_req = 1'b1; r1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_gnt", {46'd0, r1_gnt, r0_gnt}, (i % 2 == 0) ? 48'b01 : 48'b10);
      chk("rr_res_vld", 48'(res_vld), 48'd1);
      chk("rr_res_id", 48'(res_id), (i % 2 == 0) ? 48'd1 : 48'd0);
      chk("rr_res_data", res_data, (i % 2 == 0) ? 48'd77 : 48'd15);
      tick();
    end
    r1_req = 1'b0;
    // Accept of r1 result and new r0 grant in the same cycle
    #1;
    chk("acc_gnt_res_id", 48'(res_id), 48'd1);
    chk("acc_gnt_r0", 48'(r0_gnt), 48'd1);
    tick();

    // Back-pressure: r1 waits while the r0 result is held
    r0_req = 1'b0; r1_req = 1'b1; res_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_r1_gnt", 48'(r1_gnt), 48'd0);
      chk("bp_pipe_down", 48'(pipe_down), 48'd0);
      chk("bp_res_vld", 48'(res_vld), 48'd1);
      chk("bp_res_id", 48'(res_id), 48'd0);
      chk("bp_res_data", res_data, 48'd15);
      tick();
    end
    res_rdy = 1'b1;
    #1;
    chk("bp_release_gnt", 48'(r1_gnt), 48'd1);
    tick();
    r1_req = 1'b0;
    #1;
    chk("bp_r1_res_id", 48'(res_id), 48'd1);
    chk("bp_r1_res_data", res_data, 48'd77);

    // Warm-up requested while a result is pending
    res_rdy = 1'b0; warm_up_req = 1'b1;
    #1;
    chk("wu_req_cycle", 48'(warm_up), 48'd0);
    tick();
    warm_up_req = 1'b0; r0_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("wu_wait_warm", 48'(warm_up), 48'd0);
      chk("wu_wait_gnt", 48'(r0_gnt), 48'd0);
      chk("wu_wait_res_vld", 48'(res_vld), 48'd1);
      tick();
    end
    res_rdy = 1'b1;
    #1;
    chk("wu_accept_gnt", 48'(r0_gnt), 48'd0);
    chk("wu_accept_warm", 48'(warm_up), 48'd0);
    tick();
    chk("wu_drained", 48'(res_vld), 48'd0);
    chk("wu_last_wait", 48'(warm_up), 48'd0);
    chk("wu_last_wait_gnt", 48'(r0_gnt), 48'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      // flush and a stray warm_up_req mid-sequence must be ignored
      flush = (i == 1);
      warm_up_req = (i == 1);
      #1;
      chk("wu_pulse", 48'(warm_up), 48'd1);
      chk("wu_no_gnt", {46'd0, pipe_down, r0_gnt}, 48'd0);
      chk("wu_res_vld", 48'(res_vld), 48'd0);
      tick();
    end
    flush = 1'b0; warm_up_req = 1'b0;
    #1;
    chk("wu_done_warm", 48'(warm_up), 48'd0);
    chk("wu_done_gnt", 48'(r0_gnt), 48'd1);
    tick();
    chk("wu_done_res", res_data, 48'd15);

    // Flush with a pending result and r0 requesting
    flush = 1'b1; res_rdy = 1'b0;
    #1;
    chk("fl_gnt", 48'(r0_gnt), 48'd0);
    chk("fl_pipe_down", 48'(pipe_down), 48'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_res_vld", 48'(res_vld), 48'd0);
    chk("fl_regrant", 48'(r0_gnt), 48'd1);
    tick();
    r0_req = 1'b0; res_rdy = 1'b1;

    // Reset in the middle of a warm-up sequence
    warm_up_req = 1'b1;
    tick();
    warm_up_req = 1'b0;
    tick();
    chk("rw_warm1", 48'(warm_up), 48'd1);
    tick();
    chk("rw_warm2", 48'(warm_up), 48'd1);
    rst = 1'b1;
    #1;
    chk("rw_rst_warm", 48'(warm_up), 48'd0);
    chk("rw_rst_res", 48'(res_vld), 48'd0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rw_after_warm", 48'(warm_up), 48'd0);
      chk("rw_after_res", 48'(res_vld), 48'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
